moore_detector_1101: RTL and testbench



---
 rtl/moore_detector_pkg.sv | 18 +
 rtl/moore_detector_1101.sv | 53 +++++
 tb/tb_moore_detector_1101.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/moore_detector_pkg.sv
// Shared types for the 1101 serial sequence detector.
// No logic here; state encoding and the fixed pattern only.
// Not applicable: the package carries no datapath or flow control.
package moore_detector_pkg;

   // One state per matched prefix length of 1101.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GOT1   = 3'd1,
      GOT11  = 3'd2,
      GOT110 = 3'd3,
      FOUND  = 3'd4
   } det_state_t;

   // Pattern the FSM recognises, oldest bit in the MSB.
   localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/moore_detector_1101.sv
// Moore detector for the serial pattern 1101 on x, overlapping matches allowed.
// Latency: z is high for the cycle after the edge that samples the 4th bit.
// No backpressure: x is sampled on every rising edge while start is high.
module moore_detector_1101
   import moore_detector_pkg::*;
(
   input  logic x,
   input  logic start,
   input  logic reset,
   input  logic clock,
   output logic z
);

   det_state_t state_q, state_d;
   logic       z_q, z_d;

   // Next-state selection: start low discards any partial match.
   always_comb begin
      state_d = state_q;
      if (!start) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = x ? GOT1  : IDLE;
            GOT1:    state_d = x ? GOT11 : IDLE;
            GOT11:   state_d = x ? GOT11 : GOT110;
            GOT110:  state_d = x ? FOUND : IDLE;
            // The trailing 1 of a match plus a new 1 already forms "11".
            FOUND:   state_d = x ? GOT11 : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Match flag decoded from the next state so z is a plain register of it.
   always_comb begin
      z_d = (state_d == FOUND);
   end

   // State and output registers; synchronous reset overrides everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
      end
   end

   assign z = z_q;

endmodule

// File: tb/tb_moore_detector_1101.sv
// Scoreboard bench for moore_detector_1101: directed vectors plus a random-timing x phase.
// Expected z per edge is queued by the driver and popped by an independent monitor.
// The monitor samples 1 time unit after each rising edge.
module tb_moore_detector_1101;
   import moore_detector_pkg::*;

   logic x, start, reset, clock, z;

   int   n_cmp  = 0;
   int   n_fail = 0;
   logic exp_q[$];
   time  last_edge = 0;
   bit   rand_done = 0;

   // Reference model state
   logic [3:0] m_shift = 4'b0;
   int         m_cnt   = 0;

   moore_detector_1101 dut (
      .x     (x),
      .start (start),
      .reset (reset),
      .clock (clock),
      .z     (z)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) last_edge = $time;

   // Shift-register reference: returns the z expected after this edge.
   function automatic logic model_step(input logic r, input logic s, input logic xv);
      if (r || !s) begin
         m_shift = 4'b0;
         m_cnt   = 0;
         return 1'b0;
      end
      m_shift = {m_shift[2:0], xv};
      if (m_cnt < 4) m_cnt++;
      return (m_shift == PATTERN) && (m_cnt >= 4);
   endfunction

   // One directed edge with a hand-computed expected z.
   task automatic vec(input logic r, input logic s, input logic xv, input logic ez);
      @(negedge clock);
      reset = r;
      start = s;
      x     = xv;
      @(posedge clock);
      exp_q.push_back(ez);
   endtask

   // Monitor: compare z against the oldest queued expectation.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            n_cmp++;
            if (z !== e) begin
               n_fail++;
               $display("FAIL z_check t=%0t z=%b expected=%b", $time, z, e);
            end
         end
      end
   end

   // z may only move at a rising edge.
   always @(z) begin
      n_cmp++;
      if ($time != last_edge) begin
         n_fail++;
         $display("FAIL z_edge_aligned t=%0t last_edge=%0t", $time, last_edge);
      end
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      x     = 1'b0;

      // Reset with x toggling and start low
      @(posedge clock);
      exp_q.push_back(1'b0);
      vec(1, 0, 1, 0);
      vec(1, 1, 0, 0);

      // Single match: 1,1,0,1,0
      vec(0, 1, 1, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 0, 0);
      vec(0, 1, 1, 1);
      vec(0, 1, 0, 0);

      // Overlap: 1,1,0,1,1,0,1 then 0
      vec(0, 0, 0, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 0, 0);
      vec(0, 1, 1, 1);
      vec(0, 1, 1, 0);
      vec(0, 1, 0, 0);
      vec(0, 1, 1, 1);
      vec(0, 1, 0, 0);

      // Start gating mid-pattern, then a fresh match
      vec(0, 1, 1, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 0, 0);
      vec(0, 0, 1, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 0, 0);
      vec(0, 1, 1, 1);

      // start low while in FOUND drops z
      vec(0, 0, 1, 0);

      // reset with start high wins over a completing 4th bit
      vec(0, 1, 1, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 0, 0);
      vec(1, 1, 1, 0);
      vec(0, 1, 1, 0);

      // Near misses: 1,0,1,1,1,0,0,1
      vec(0, 0, 0, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 0, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 1, 0);
      vec(0, 1, 0, 0);
      vec(0, 1, 0, 0);
      vec(0, 1, 1, 0);

      // Random x timing against the shift-register model
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      @(posedge clock);
      exp_q.push_back(model_step(reset, start, x));
      fork
         begin
            @(negedge clock);
            start = 1'b1;
            for (int i = 0; i < 13; i++) begin
               @(posedge clock);
               exp_q.push_back(model_step(reset, start, x));
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               int d;
               d = $urandom_range(0, 15);
               // Keep x changes off the rising edges (edges at 5 mod 10).
               if ((($time + d) % 10) == 5) d++;
               #d x = 1'($urandom_range(0, 1));
            end
         end
      join

      @(negedge clock);
      start = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
